// File: rtl/quarterwave_lut_pkg.sv
// rtl/quarterwave_lut_pkg.sv - shared constants and quadrant-entry function for the quarter-wave sine LUTs
package quarterwave_lut_pkg;

  localparam int DEF_DATA_WIDTH = 7;
  localparam int DEF_QLUT_DEPTH = 8;

  localparam longint ONE_Q30 = 64'sd1073741824;
  localparam longint PI_Q30  = 64'sd3373259426;

  function automatic int qlut_n(input int qlut_depth);
    return 1 << (qlut_depth - 2);
  endfunction

  function automatic int qlut_amp(input int data_width);
    return (1 << (data_width - 1)) - 1;
  endfunction

  localparam int DEF_N = qlut_n(DEF_QLUT_DEPTH);
  localparam int DEF_A = qlut_amp(DEF_DATA_WIDTH);

  // round(A * sin(pi*(i+0.5)/(2n))) using a Q30 Taylor series out to x^11
  function automatic int qlut_entry(input int i, input int n, input int dw);
    longint amp;
    longint x;
    longint x2;
    longint t;
    longint s;
    longint v;
    amp = (64'sd1 <<< (dw - 1)) - 64'sd1;
    x   = (PI_Q30 * longint'(2 * i + 1)) / longint'(4 * n);
    x2  = (x * x) >>> 30;
    t   = ONE_Q30;
    t   = ONE_Q30 - ((x2 * t) >>> 30) / 110;
    t   = ONE_Q30 - ((x2 * t) >>> 30) / 72;
    t   = ONE_Q30 - ((x2 * t) >>> 30) / 42;
    t   = ONE_Q30 - ((x2 * t) >>> 30) / 20;
    t   = ONE_Q30 - ((x2 * t) >>> 30) / 6;
    s   = (x * t) >>> 30;
    v   = (amp * s + (64'sd1 <<< 29)) >>> 30;
    if (v < 0) v = 0;
    if (v > amp) v = amp;
    return int'(v);
  endfunction

endpackage

// File: rtl/quarterwave_lut.sv
// rtl/quarterwave_lut.sv - first-quadrant sine ROM with a single clock-enabled output register
module quarterwave_lut
  import quarterwave_lut_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int QLUT_DEPTH = DEF_QLUT_DEPTH
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         ce,
  input  logic [QLUT_DEPTH-3:0]        address,
  output logic signed [DATA_WIDTH-1:0] value
);

  localparam int N = qlut_n(QLUT_DEPTH);

  generate
    if (QLUT_DEPTH < 3 || DATA_WIDTH < 2) begin : g_bad_params
      $error("quarterwave_lut: requires QLUT_DEPTH >= 3 and DATA_WIDTH >= 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rom [N];

  // Contents are elaboration-time constants; no memory file is involved.
  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom[g] = DATA_WIDTH'(qlut_entry(g, N, DATA_WIDTH));
  end

  logic [DATA_WIDTH-1:0] value_d;
  logic [DATA_WIDTH-1:0] value_q;

  always_comb begin
    value_d = rom[address];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      value_q <= '0;
    end else if (ce) begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: tb/tb_quarterwave_lut.sv
// tb/tb_quarterwave_lut.sv - directed table-driven bench for quarterwave_lut
module tb_quarterwave_lut;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              ce = 1'b0;
  logic [5:0]        address = '0;
  logic signed [6:0] value;

  logic               ce2 = 1'b0;
  logic [7:0]         address2 = '0;
  logic signed [11:0] value2;

  int checks = 0;
  int failures = 0;

  quarterwave_lut #(.DATA_WIDTH(7), .QLUT_DEPTH(8)) dut (
    .clk(clk), .arst_n(arst_n), .ce(ce), .address(address), .value(value)
  );

  quarterwave_lut #(.DATA_WIDTH(12), .QLUT_DEPTH(10)) dut_wide (
    .clk(clk), .arst_n(arst_n), .ce(ce2), .address(address2), .value(value2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    ce;
    int    addr;
    int    exp;
    string name;
  } vec_t;

  function automatic int model(input int i, input int n, input int dw);
    real a;
    real x;
    a = real'((1 << (dw - 1)) - 1);
    x = 3.14159265358979 * (real'(i) + 0.5) / (2.0 * real'(n));
    return int'($floor(a * $sin(x) + 0.5));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  int   swept[64];

  initial begin
    vec_t v;

    for (int i = 0; i < 64; i++) begin
      v.ce = 1'b1; v.addr = i; v.exp = model(i, 64, 7); v.name = $sformatf("sweep_%0d", i);
      if (i == 0)  begin v.exp = 1;  v.name = "ckpt_0";  end
      if (i == 31) begin v.exp = 44; v.name = "ckpt_31"; end
      if (i == 32) begin v.exp = 45; v.name = "ckpt_32"; end
      if (i == 63) begin v.exp = 63; v.name = "ckpt_63"; end
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 40, 63, "hold_addr40"});
    vecs.push_back('{1'b0, 5,  63, "hold_addr5"});
    vecs.push_back('{1'b1, 40, model(40, 64, 7), "enable_40"});
    vecs.push_back('{1'b1, 63, 63, "wrap_top"});
    vecs.push_back('{1'b1, 0,  1,  "wrap_zero"});
    vecs.push_back('{1'b1, 1,  model(1, 64, 7), "wrap_next"});

    // Reset held with a live address and enable: output must stay cleared.
    arst_n = 1'b0; ce = 1'b1; address = 6'd63;
    step();
    chk("reset_value", int'(value), 0);
    step();
    chk("reset_value_held", int'(value), 0);
    chk("reset_value_wide", int'(value2), 0);
    #3 arst_n = 1'b1;
    step();
    chk("first_edge_after_reset", int'(value), 63);

    for (int t = 0; t < vecs.size(); t++) begin
      ce = vecs[t].ce;
      address = 6'(vecs[t].addr);
      step();
      chk(vecs[t].name, int'(value), vecs[t].exp);
      if (t < 64) begin
        swept[t] = int'(value);
        chk($sformatf("nonneg_%0d", t), int'(value >= 0), 1);
        if (t > 0) chk($sformatf("monotonic_%0d", t), int'(swept[t] >= swept[t-1]), 1);
      end
    end

    for (int i = 0; i < 32; i++) begin
      chk($sformatf("symmetry_%0d", i), swept[i] + swept[63-i],
          model(i, 64, 7) + model(63 - i, 64, 7));
    end

    // Asynchronous clear between edges, then recovery with no warm-up cycle.
    ce = 1'b1; address = 6'd10;
    step();
    address = 6'd11;
    step();
    chk("pre_async_value", int'(value), model(11, 64, 7));
    #2 arst_n = 1'b0;
    #1 chk("async_clear_immediate", int'(value), 0);
    step();
    chk("async_clear_held", int'(value), 0);
    #3 arst_n = 1'b1;
    address = 6'd17;
    step();
    chk("resume_after_reset", int'(value), model(17, 64, 7));

    ce = 1'b0;
    ce2 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      int e;
      int d;
      address2 = 8'(i);
      step();
      e = model(i, 256, 12);
      d = int'(value2) - e;
      if (d < -1 || d > 1) begin
        chk($sformatf("wide_entry_%0d", i), int'(value2), e);
      end else begin
        checks++;
      end
    end
    chk("wide_entry_255", int'(value2), 2047);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quarterwave_lut.md
# quarterwave_lut

Synchronous quarter-wave sine ROM for the quarter-table sine/cosine generator. It stores the first quadrant of a sine wave at half-step phase offsets. The owning generator mirrors and negates the stored quadrant to produce a full period. Sine and cosine each use one instance, addressed by the generator's index registers. Each instance returns a signed, non-negative magnitude one clock-enabled cycle after the address is presented.

## Interface
Parameters:
- DATA_WIDTH, 7: width of the signed output sample; full-scale amplitude A = 2^(DATA_WIDTH-1) - 1.
- QLUT_DEPTH, 8: log2 of the full-period table size; the stored quadrant has N = 2^(QLUT_DEPTH-2) entries.

Ports:
- clk  input  1: single clock; all state updates on its rising edge.
- arst_n  input  1: asynchronous, active-low reset.
- ce  input  1: clock enable, the generator's sample_clk_ce; the output register updates only when ce=1.
- address  input  QLUT_DEPTH-2: quadrant index i, range 0..N-1.
- value  output  signed DATA_WIDTH: registered table entry for the address sampled on the last enabled edge.

## Operation
- Entry formula: value(i) = round(A * sin((pi/2) * (i + 0.5) / N)).
  - Rounding is half-up.
  - All entries are in [0, A] and are monotonically non-decreasing in i.
- The half-step offset makes entry N-1-i the exact mirror of entry i. The generator's bitwise-NOT of the index therefore reflects the quadrant without duplicating or skipping a sample.
- Contents are computed at elaboration by a constant function, with no external memory file.
  - The function uses a fixed-point or real polynomial sine evaluation.
  - Accuracy: each entry within ±1 LSB of the exact formula above; for the default parameters, entries match the exact formula with no error.
- Storage is a ROM array of N words of DATA_WIDTH bits. It is read into a single output register.
- Default checkpoints (DATA_WIDTH=7, QLUT_DEPTH=8, N=64, A=63):
  - i=0 → 1
  - i=31 → 44
  - i=32 → 45
  - i=63 → 63
- Parameter legality:
  - QLUT_DEPTH ≥ 3 and DATA_WIDTH ≥ 2.
  - An elaboration-time check fails the build otherwise.

## Timing
- Latency: exactly 1 enabled cycle.
  - If address = a before an edge with ce=1, value = table(a) after that edge.
  - The generator's negate pipeline is sized for this latency; do not add a second register stage.
- ce=0: value holds its previous contents, and address is ignored.
- Reset:
  - arst_n low forces value = 0 immediately, independent of clk.
  - On deassertion, value stays 0 until the first enabled edge.
- Reset asserted mid-stream: the output clears at once. The first enabled edge after release returns table(address) with no warm-up.
- Address wrap: address N-1 followed by 0 yields A (or the top entry), then the i=0 entry, with no glitch cycle.
- No combinational path from address to value.

## Structure
- Shared package (e.g. sine_lut_pkg) holds:
  - the constant function computing a quadrant entry from (i, N, DATA_WIDTH);
  - helper localparams for N and A.
- The generator and any full-wave or alternate LUT variants reuse this package.
- Single module; no sub-modules are needed. The ROM array is filled by a generate loop or an initial constant-function loop, followed by the output register.

## Test plan
- Reset: hold arst_n=0 with address=63 and ce=1 → value=0. Release it, then clock one edge → value=63.
- Sweep: ce=1, address 0..63 over consecutive cycles → value one cycle later equals the exact formula (1 … 44, 45 … 63), monotonic, never negative.
- Symmetry: for every i, value(i) + value(63-i) equals the sum predicted by the formula; specifically value(0)=1 and value(63)=63.
- Enable: set ce=0, change address 0→40 → value holds its old word. Raise ce for one edge → value = table(40).
- Async reset mid-sweep: assert arst_n low between edges → value goes to 0 before the next clk edge. Resume → correct latency-1 data.
- Parameter sweep: DATA_WIDTH=12, QLUT_DEPTH=10 → entry 255 = 2047, and every entry is within ±1 LSB of the real-valued formula.
